seven_seg_scan_controller: RTL and testbench

- Time-multiplexes a multi-digit BCD display (watch HH:MM:SS) onto one shared seven-segment decoder and one shared segment bus.
- Each scan slot presents one BCD nibble to the decoder and asserts that digit's select line.
- Handles inter-digit blanking (anti-ghosting), leading-zero suppression, setting-mode blink and per-frame snapshotting of the displayed value.
- Sits between the watch counters/setting FSM and the decoder plus digit drivers.

---
 rtl/seven_seg_scan_controller.sv | 124 ++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: time-multiplexed BCD display scanner with blanking, blink and leading-zero suppression
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS   = 6,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    seg_en,
  output logic                    frame_start
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  r_state, w_state;
  logic [IW-1:0]           r_idx, w_idx;
  logic [CW-1:0]           r_cnt, w_cnt;
  logic [FW-1:0]           r_frame, w_frame;
  logic                    r_phase, w_phase;
  logic [4*NUM_DIGITS-1:0] r_snap, w_snap;
  logic                    w_fs;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic                    w_sup;
  logic [3:0]              r_bcd;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_seg_en, r_fs;

  // next-state: slot timing, digit advance, frame wrap with snapshot and blink bookkeeping
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_cnt   = r_cnt + 1'b1;
    w_frame = r_frame;
    w_phase = r_phase;
    w_snap  = r_snap;
    w_fs    = 1'b0;
    if (!enable) begin
      w_state = IDLE;
      w_idx   = '0;
      w_cnt   = '0;
      w_frame = '0;
      w_phase = 1'b0;
    end else if (r_state == IDLE) begin
      w_state = BLANK;
      w_idx   = '0;
      w_cnt   = '0;
      w_snap  = digits_in;
      w_fs    = 1'b1;
    end else if (r_state == BLANK && r_cnt == BLANK_LAST) begin
      w_state = SHOW;
      w_cnt   = '0;
    end else if (r_state == SHOW && r_cnt == SHOW_LAST) begin
      w_state = BLANK;
      w_cnt   = '0;
      w_idx   = r_idx + 1'b1;
      if (r_idx == LAST_IDX) begin
        w_idx   = '0;
        w_snap  = digits_in;
        w_fs    = 1'b1;
        w_frame = r_frame == FRAME_LAST ? '0 : r_frame + 1'b1;
        w_phase = r_phase ^ (r_frame == FRAME_LAST);
      end
    end
  end

  // select the upcoming digit's nibble and decide whether its segments must stay dark
  always_comb begin
    w_nib = '0;
    w_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (w_idx == IW'(i)) begin
        w_nib    = w_snap[4*i +: 4];
        w_sel[i] = 1'b1;
      end
    w_sup = (w_phase && |(blink_mask & w_sel)) || (w_idx == LAST_IDX && lz_blank && w_nib == 4'd0) || w_nib > 4'd9;
  end

  // state and output registers; outputs reflect the state being entered so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_frame  <= '0;
      r_phase  <= 1'b0;
      r_snap   <= '0;
      r_bcd    <= '0;
      r_sel    <= '0;
      r_seg_en <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_cnt    <= w_cnt;
      r_frame  <= w_frame;
      r_phase  <= w_phase;
      r_snap   <= w_snap;
      r_bcd    <= w_state == IDLE ? '0 : w_nib;
      r_sel    <= w_state == SHOW ? w_sel : '0;
      r_seg_en <= w_state == SHOW && !w_sup;
      r_fs     <= w_fs;
    end
  end

  assign digit_bcd   = r_bcd;
  assign digit_sel   = r_sel;
  assign seg_en      = r_seg_en;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller: scoreboard bench for the display scan controller
module tb_seven_seg_scan_controller;
  localparam int N = 6;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, lz_blank = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0] blink_mask = '0;
  logic [3:0] digit_bcd;
  logic [N-1:0] digit_sel;
  logic seg_en, frame_start;
  typedef struct packed {logic [3:0] bcd; logic [N-1:0] sel; logic en;} exp_t;
  exp_t q[$];
  exp_t cur = '0;
  int total = 0, bad = 0;
  logic [N-1:0] prev_sel = '0;
  int slot_len = 0, last_fs = -1, cyc = 0;

  always #5 clk = ~clk;

  seven_seg_scan_controller #(.NUM_DIGITS(N), .PRESCALE(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(rst), .enable(enable), .digits_in(digits_in), .blink_mask(blink_mask),
    .lz_blank(lz_blank), .digit_bcd(digit_bcd), .digit_sel(digit_sel), .seg_en(seg_en),
    .frame_start(frame_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [4*N-1:0] d, input logic [N-1:0] en, input int n);
    for (int i = 0; i < n; i++) q.push_back(exp_t'({d[4*i +: 4], N'(1) << i, en[i]}));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_bcd"}, 32'(digit_bcd), 0);
    check({tag, "_sel"}, 32'(digit_sel), 0);
    check({tag, "_seg_en"}, 32'(seg_en), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  // monitor: pops an expected slot at each SHOW start, holds it through the slot, checks slot length and frame period
  always @(negedge clk) begin
    cyc++;
    check("onehot", 32'($countones(digit_sel) <= 1), 1);
    if (rst || !enable) last_fs = -1;
    else if (frame_start) begin
      if (last_fs >= 0) check("frame_period", cyc - last_fs, 48);
      last_fs = cyc;
    end
    if (digit_sel != 0 && prev_sel == 0) begin
      slot_len = 1;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL slot_unexpected: got %0h want none", {digit_bcd, digit_sel, seg_en});
      end else begin
        cur = q.pop_front();
        check("slot", 32'({digit_bcd, digit_sel, seg_en}), 32'(cur));
      end
    end else if (digit_sel != 0) begin
      slot_len++;
      check("slot_hold", 32'({digit_bcd, digit_sel, seg_en}), 32'(cur));
    end else if (prev_sel != 0 && !rst && enable) check("show_len", slot_len, 6);
    prev_sel = digit_sel;
  end

  initial begin
    tick(3);
    check_dark("reset");
    rst = 1'b0;
    tick(1);
    enable = 1'b1;
    digits_in = 24'h123456;
    push_frame(24'h123456, 6'h3F, 6);
    tick(1);
    check("first_fs", 32'(frame_start), 1);
    check("first_blank_bcd", 32'(digit_bcd), 6);
    check("first_blank_sel", 32'(digit_sel), 0);
    check("first_blank_seg", 32'(seg_en), 0);
    tick(1);
    check("blank2_fs", 32'(frame_start), 0);
    check("blank2_bcd", 32'(digit_bcd), 6);
    check("blank2_sel", 32'(digit_sel), 0);
    push_frame(24'h999999, 6'h3F, 6);
    tick(18);
    digits_in = 24'h999999;
    tick(40);
    digits_in = 24'h012345;
    lz_blank = 1'b1;
    push_frame(24'h012345, 6'h1F, 6);
    push_frame(24'h012345, 6'h3F, 6);
    tick(86);
    lz_blank = 1'b0;
    tick(4);
    digits_in = 24'h123456;
    push_frame(24'h123456, 6'h3F, 4);
    tick(70);
    enable = 1'b0;
    tick(1);
    check_dark("disable");
    tick(2);
    enable = 1'b1;
    digits_in = 24'h123C56;
    blink_mask = 6'b000011;
    push_frame(24'h123C56, 6'h3B, 6);
    push_frame(24'h123C56, 6'h3B, 6);
    push_frame(24'h123C56, 6'h38, 6);
    push_frame(24'h123C56, 6'h38, 6);
    push_frame(24'h123C56, 6'h3B, 1);
    tick(1);
    check("reenable_fs", 32'(frame_start), 1);
    check("reenable_bcd", 32'(digit_bcd), 6);
    tick(195);
    rst = 1'b1;
    tick(1);
    check_dark("mid_reset");
    tick(3);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
